// File: rtl/sdu_spectrum_avg.sv
// Doppler spectrum back end: unloads the FFT, averages per-bin power over 2**LOG2_NAVG frames,
// streams the averaged spectrum with valid/ready and reports the peak bin.
//
// state     | meaning
// S_IDLE    | waiting for fft_done
// S_UNLOAD  | one-cycle fft_unload request
// S_CAPTURE | counting fft_dv beats into the power pipeline
// S_DRAIN   | letting the last beats reach the accumulator RAM
// S_OUTPUT  | streaming averaged bins 0..NFFT-1
module sdu_spectrum_avg #(
   parameter int NFFT         = 128,
   parameter int LOG2_NFFT    = 7,
   parameter int SHIFT        = 8,
   parameter int LOG2_NAVG    = 2,
   parameter int PEAK_SKIP_DC = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 fft_done,
   output logic                 fft_unload,
   input  logic                 fft_dv,
   input  logic [31:0]          din_re,
   input  logic [31:0]          din_im,
   output logic                 spec_valid,
   input  logic                 spec_ready,
   output logic [LOG2_NFFT-1:0] spec_bin,
   output logic [31:0]          spec_pow,
   output logic                 spec_last,
   output logic                 peak_valid,
   output logic [LOG2_NFFT-1:0] peak_bin,
   output logic [31:0]          peak_pow,
   output logic                 busy
);

   localparam int ACCW = 32 + LOG2_NAVG;
   localparam logic [LOG2_NFFT-1:0] LAST_BIN  = LOG2_NFFT'(NFFT - 1);
   localparam logic [LOG2_NFFT-1:0] FIRST_BIN = LOG2_NFFT'((PEAK_SKIP_DC != 0) ? 1 : 0);
   localparam logic [LOG2_NAVG-1:0] LAST_FRM  = LOG2_NAVG'((1 << LOG2_NAVG) - 1);

   typedef enum logic [2:0] {S_IDLE, S_UNLOAD, S_CAPTURE, S_DRAIN, S_OUTPUT} state_t;
   state_t r_state, w_next;

   logic [LOG2_NFFT-1:0] r_bin, r_s1_bin, r_p_bin, r_rd_addr, r_pf_bin, r_run_bin;
   logic [LOG2_NAVG-1:0] r_frame_cnt;
   logic                 r_s1_vld, r_p_vld, r_rd_done, r_pf_vld;
   logic signed [15:0]   r_s_re, r_s_im;
   logic [31:0]          r_pow, r_pf_pow, r_run_pow;
   logic [ACCW-1:0]      r_acc [NFFT];
   logic signed [31:0]   w_sq_re, w_sq_im;
   logic [31:0]          w_pow, w_pk_pow;
   logic [LOG2_NFFT-1:0] w_pk_bin;
   logic                 w_drain_done, w_hs, w_pf_take, w_issue, w_upd;

   function automatic logic signed [15:0] sat_scale(input logic [31:0] din);
      logic signed [31:0] v;
      v = $signed(din) >>> SHIFT;
      if (v > 32'sd32767)       return 16'sh7FFF;
      else if (v < -32'sd32767) return 16'sh8001;
      else                      return 16'(v);
   endfunction

   assign w_sq_re      = r_s_re * r_s_re;
   assign w_sq_im      = r_s_im * r_s_im;
   assign w_pow        = $unsigned(w_sq_re) + $unsigned(w_sq_im);
   assign w_drain_done = (r_state == S_DRAIN) && !r_s1_vld && !r_p_vld;
   assign w_hs         = spec_valid && spec_ready;
   assign w_pf_take    = r_pf_vld && (!spec_valid || w_hs);
   assign w_issue      = (r_state == S_OUTPUT) && !r_rd_done && (!r_pf_vld || w_pf_take);
   // Ties keep the earlier bin because only a strictly larger value replaces the peak.
   assign w_upd        = !((PEAK_SKIP_DC != 0) && (spec_bin == '0)) &&
                         ((spec_bin == FIRST_BIN) || (spec_pow > r_run_pow));
   assign w_pk_bin     = w_upd ? spec_bin : r_run_bin;
   assign w_pk_pow     = w_upd ? spec_pow : r_run_pow;
   assign fft_unload   = (r_state == S_UNLOAD);
   assign busy         = (r_state != S_IDLE);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (fft_done) w_next = S_UNLOAD;
         S_UNLOAD:  w_next = S_CAPTURE;
         S_CAPTURE: if (fft_dv && (r_bin == LAST_BIN)) w_next = S_DRAIN;
         S_DRAIN:   if (w_drain_done) w_next = (r_frame_cnt == LAST_FRM) ? S_OUTPUT : S_IDLE;
         S_OUTPUT:  if (w_hs && spec_last) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      r_s_re   <= sat_scale(din_re);
      r_s_im   <= sat_scale(din_im);
      r_s1_bin <= r_bin;
      r_pow    <= w_pow;
      r_p_bin  <= r_s1_bin;
   end

   // Frame 0 of an average overwrites, so the RAM never needs clearing.
   always_ff @(posedge clk) begin
      if (r_p_vld)
         r_acc[r_p_bin] <= (r_frame_cnt == '0) ? ACCW'(r_pow) : r_acc[r_p_bin] + ACCW'(r_pow);
      if (w_issue)
         r_pf_pow <= 32'(r_acc[r_rd_addr] >> LOG2_NAVG);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_bin       <= '0;
         r_frame_cnt <= '0;
         r_s1_vld    <= 1'b0;
         r_p_vld     <= 1'b0;
         r_rd_addr   <= '0;
         r_rd_done   <= 1'b0;
         r_pf_vld    <= 1'b0;
         r_pf_bin    <= '0;
         r_run_bin   <= '0;
         r_run_pow   <= '0;
         spec_valid  <= 1'b0;
         spec_bin    <= '0;
         spec_pow    <= '0;
         spec_last   <= 1'b0;
         peak_valid  <= 1'b0;
         peak_bin    <= '0;
         peak_pow    <= '0;
      end else begin
         r_state  <= w_next;
         r_s1_vld <= (r_state == S_CAPTURE) && fft_dv;
         r_p_vld  <= r_s1_vld;
         if (r_state == S_UNLOAD)
            r_bin <= '0;
         else if ((r_state == S_CAPTURE) && fft_dv)
            r_bin <= r_bin + 1'b1;
         if (w_drain_done && (r_frame_cnt != LAST_FRM))
            r_frame_cnt <= r_frame_cnt + 1'b1;
         else if (w_hs && spec_last)
            r_frame_cnt <= '0;
         if (w_drain_done) begin
            r_rd_addr <= '0;
            r_rd_done <= 1'b0;
            r_pf_vld  <= 1'b0;
         end else if (w_issue) begin
            r_pf_vld  <= 1'b1;
            r_pf_bin  <= r_rd_addr;
            r_rd_addr <= r_rd_addr + 1'b1;
            if (r_rd_addr == LAST_BIN) r_rd_done <= 1'b1;
         end else if (w_pf_take) begin
            r_pf_vld <= 1'b0;
         end
         if (w_pf_take) begin
            spec_valid <= 1'b1;
            spec_bin   <= r_pf_bin;
            spec_pow   <= r_pf_pow;
            spec_last  <= (r_pf_bin == LAST_BIN);
         end else if (w_hs) begin
            spec_valid <= 1'b0;
         end
         if (w_hs) begin
            r_run_bin <= w_pk_bin;
            r_run_pow <= w_pk_pow;
         end
         peak_valid <= w_hs && spec_last;
         if (w_hs && spec_last) begin
            peak_bin <= w_pk_bin;
            peak_pow <= w_pk_pow;
         end
      end
   end

endmodule

// File: tb/tb_sdu_spectrum_avg.sv
// Scoreboard bench for sdu_spectrum_avg: frames are driven from stimulus tables, a reference
// model queues the expected averaged spectrum and peak, and a monitor checks every handshake.
module tb_sdu_spectrum_avg;

   localparam int NFFT  = 128;
   localparam int NAVG  = 4;
   localparam int SHIFT = 8;

   typedef struct {logic [6:0] bin; logic [31:0] pow; logic last;} word_t;
   typedef struct {logic [6:0] bin; logic [31:0] pow;} peak_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        fft_done = 1'b0;
   logic        fft_unload;
   logic        fft_dv = 1'b0;
   logic [31:0] din_re = '0;
   logic [31:0] din_im = '0;
   logic        spec_valid;
   logic        spec_ready = 1'b1;
   logic [6:0]  spec_bin;
   logic [31:0] spec_pow;
   logic        spec_last;
   logic        peak_valid;
   logic [6:0]  peak_bin;
   logic [31:0] peak_pow;
   logic        busy;

   int    n_vec = 0, n_err = 0;
   int    n_unload = 0, n_peak = 0, n_hs = 0;
   bit    rand_ready = 1'b0;
   int    re_tab [NAVG][NFFT];
   int    im_tab [NAVG][NFFT];
   word_t exp_q [$];
   peak_t pk_q [$];

   sdu_spectrum_avg dut (
      .clk(clk), .reset(reset), .fft_done(fft_done), .fft_unload(fft_unload),
      .fft_dv(fft_dv), .din_re(din_re), .din_im(din_im),
      .spec_valid(spec_valid), .spec_ready(spec_ready), .spec_bin(spec_bin),
      .spec_pow(spec_pow), .spec_last(spec_last), .peak_valid(peak_valid),
      .peak_bin(peak_bin), .peak_pow(peak_pow), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint scale(input int d);
      longint v;
      v = longint'(d) / (1 << SHIFT);
      if ((d < 0) && (v * (1 << SHIFT) != longint'(d))) v = v - 1;  // floor toward -inf
      if (v > 32767)  v = 32767;
      if (v < -32767) v = -32767;
      return v;
   endfunction

   function automatic void push_expected();
      longint avg [NFFT];
      int     best;
      for (int b = 0; b < NFFT; b++) begin
         longint acc = 0;
         for (int f = 0; f < NAVG; f++)
            acc += scale(re_tab[f][b]) * scale(re_tab[f][b]) + scale(im_tab[f][b]) * scale(im_tab[f][b]);
         avg[b] = acc / NAVG;
         exp_q.push_back('{bin: 7'(b), pow: 32'(avg[b]), last: (b == NFFT - 1)});
      end
      best = 1;
      for (int b = 2; b < NFFT; b++)
         if (avg[b] > avg[best]) best = b;
      pk_q.push_back('{bin: 7'(best), pow: 32'(avg[best])});
   endfunction

   function automatic void fill(input int re, input int im);
      for (int f = 0; f < NAVG; f++)
         for (int b = 0; b < NFFT; b++) begin
            re_tab[f][b] = re;
            im_tab[f][b] = im;
         end
   endfunction

   // spec_ready changes just after posedge, so the monitor sees the value the DUT will sample.
   initial forever begin
      @(posedge clk);
      #1 spec_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   initial begin : monitor
      bit    stall = 1'b0;
      word_t held;
      word_t e;
      peak_t p;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               check("stall_valid", spec_valid, 1);
               check("stall_bin", spec_bin, held.bin);
               check("stall_pow", spec_pow, held.pow);
               check("stall_last", spec_last, held.last);
            end
            if (fft_unload === 1'b1) n_unload++;
            if (spec_valid === 1'b1 && spec_ready === 1'b1) begin
               n_hs++;
               if (exp_q.size() == 0) begin
                  check("unexpected_word", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("spec_bin", spec_bin, e.bin);
                  check("spec_pow", spec_pow, e.pow);
                  check("spec_last", spec_last, e.last);
               end
            end
            if (peak_valid === 1'b1) begin
               n_peak++;
               if (pk_q.size() == 0) begin
                  check("unexpected_peak", 1, 0);
               end else begin
                  p = pk_q.pop_front();
                  check("peak_bin", peak_bin, p.bin);
                  check("peak_pow", peak_pow, p.pow);
               end
            end
            stall = (spec_valid === 1'b1) && (spec_ready !== 1'b1);
            held  = '{bin: spec_bin, pow: spec_pow, last: spec_last};
         end
      end
   end

   // Inputs change on negedge; garbage with fft_dv=1 outside CAPTURE must be ignored.
   task automatic drive_frame(input int f, input bit gaps, input int stop_beat);
      int t;
      t = 0;
      fft_dv = gaps;
      din_re = $urandom;
      din_im = $urandom;
      while (busy !== 1'b0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("idle_timeout", t < 2000, 1);
      fft_done = 1'b1;
      @(negedge clk);
      t = 0;
      while (fft_unload !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("unload_timeout", t < 50, 1);
      fft_done = 1'b0;
      @(negedge clk);
      for (int k = 0; k < NFFT; k++) begin
         if (k == stop_beat) return;
         fft_dv   = 1'b1;
         din_re   = re_tab[f][k];
         din_im   = im_tab[f][k];
         fft_done = gaps && (k == 50);
         @(negedge clk);
         if (gaps) begin
            fft_dv   = 1'b0;
            fft_done = 1'b0;
            din_re   = $urandom;
            din_im   = $urandom;
            @(negedge clk);
         end
      end
      fft_dv   = 1'b0;
      fft_done = 1'b0;
   endtask

   task automatic run_avg(input bit gaps);
      int t;
      n_unload = 0;
      n_peak   = 0;
      n_hs     = 0;
      push_expected();
      for (int f = 0; f < NAVG; f++) drive_frame(f, gaps, NFFT);
      t = 0;
      while ((exp_q.size() != 0 || pk_q.size() != 0 || busy !== 1'b0) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      check("run_timeout", t < 5000, 1);
      repeat (3) @(negedge clk);
      check("unload_pulses", n_unload, NAVG);
      check("peak_pulses", n_peak, 1);
      check("handshakes", n_hs, NFFT);
      exp_q.delete();
      pk_q.delete();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_spec_valid"}, spec_valid, 0);
      check({tag, "_spec_pow"}, spec_pow, 0);
      check({tag, "_spec_bin"}, spec_bin, 0);
      check({tag, "_peak_valid"}, peak_valid, 0);
      check({tag, "_peak_bin"}, peak_bin, 0);
      check({tag, "_peak_pow"}, peak_pow, 0);
      check({tag, "_unload"}, fft_unload, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_state("rst");
      reset = 1'b1;
      @(negedge clk);

      fill(8192, 0);
      run_avg(1'b0);

      fill(32'h7FFFFFFF, 32'h80000000);
      run_avg(1'b0);

      fill(0, 0);
      for (int f = 0; f < NAVG; f++) re_tab[f][37] = 65536;
      run_avg(1'b0);

      for (int f = 0; f < NAVG; f++)
         for (int b = 0; b < NFFT; b++) begin
            re_tab[f][b] = ($urandom_range(0, 3) == 0) ? int'($urandom) : (int'($urandom) >>> 12);
            im_tab[f][b] = ($urandom_range(0, 3) == 0) ? int'($urandom) : (int'($urandom) >>> 12);
         end
      rand_ready = 1'b1;
      run_avg(1'b0);
      rand_ready = 1'b0;

      fill(-8192, 0);
      run_avg(1'b1);

      fill(8192, 0);
      drive_frame(0, 1'b0, NFFT);
      drive_frame(1, 1'b0, NFFT);
      drive_frame(2, 1'b0, 60);
      reset  = 1'b0;
      fft_dv = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_reset_state("midrst");
      reset = 1'b1;
      @(negedge clk);
      run_avg(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
